// File: rtl/adder_seq.sv
// adder_seq: registered WIDTH-bit unsigned adder built from a generate-built
// ripple chain of half_adder / full_adder leaf cells.
// Optional feature macro: ADDER_SEQ_INREG_EN adds input registers on in1/in2,
// raising latency from 1 to 2 clocks. Port list and arithmetic are unchanged.

// Single-bit half adder: no state, no reset.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

// Single-bit full adder: no state, no reset.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// Top: ripple-carry sum of in1 + in2, registered onto out/carry_out.
module adder_seq #(
    parameter int unsigned WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             carry_out
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

`ifdef ADDER_SEQ_INREG_EN
    logic [WIDTH-1:0] in1_q;
    logic [WIDTH-1:0] in2_q;

    // Operand capture stage; cleared with the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in1_q <= '0;
            in2_q <= '0;
        end else begin
            in1_q <= in1;
            in2_q <= in2;
        end
    end

    assign op_a = in1_q;
    assign op_b = in2_q;
`else
    assign op_a = in1;
    assign op_b = in2;
`endif

    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] carry_w;

    // Bit 0 has no carry-in, so it uses a half adder; every higher bit
    // takes its carry-in from the bit below.
    half_adder u_ha0 (
        .a     (op_a[0]),
        .b     (op_b[0]),
        .sum   (sum_w[0]),
        .carry (carry_w[0])
    );

    for (genvar i = 1; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (op_a[i]),
            .b    (op_b[i]),
            .cin  (carry_w[i-1]),
            .sum  (sum_w[i]),
            .cout (carry_w[i])
        );
    end

    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             carry_d;
    logic             carry_q;

    assign out_d   = sum_w;
    assign carry_d = carry_w[WIDTH-1];

    // Result register: loads the chain output every cycle, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign out       = out_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_adder_seq.sv
// Self-checking bench for adder_seq: directed corner cases plus a random
// operand stream compared to an arithmetic reference with a latency queue.
module tb_adder_seq;

    localparam int unsigned WIDTH = 1024;
`ifdef ADDER_SEQ_INREG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] out;
    logic             carry_out;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [WIDTH:0] exp_q[$];

    adder_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk_out(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: out observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_cy(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: carry_out observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Reference model state after reset: the pipeline holds zeros.
    task automatic model_reset();
        exp_q.delete();
        for (int i = 1; i < int'(LAT); i++) exp_q.push_back('0);
    endtask

    // Present operands for one edge, then compare against the model.
    task automatic apply(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
        logic [WIDTH:0] e;
        in1 = a;
        in2 = b;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, a} + {1'b0, b});
        e = exp_q.pop_front();
        chk_out(tag, out, e[WIDTH-1:0]);
        chk_cy(tag, carry_out, e[WIDTH]);
    endtask

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] exp_w;

    initial begin
        ones  = '1;
        rst_n = 1'b0;
        in1   = '0;
        in2   = '0;

        // Reset held with clock running and operands moving.
        for (int i = 0; i < 4; i++) begin
            in1 = rnd_word();
            in2 = rnd_word();
            @(posedge clk);
            #1;
            chk_out("reset_hold", out, '0);
            chk_cy("reset_hold", carry_out, 1'b0);
        end
        #3;
        rst_n = 1'b1;
        model_reset();

        // 5 + 3 held for LAT edges, then checked against a constant.
        for (int i = 0; i < int'(LAT); i++) apply("add_5_3", 5, 3);
        exp_w = 8;
        chk_out("add_5_3_const", out, exp_w);
        chk_cy("add_5_3_const", carry_out, 1'b0);

        // Full-width ripple: all ones + 1 wraps to 0 with carry.
        for (int i = 0; i < int'(LAT); i++) apply("ones_plus_1", ones, 1);
        chk_out("ones_plus_1_const", out, '0);
        chk_cy("ones_plus_1_const", carry_out, 1'b1);

        // All ones + all ones.
        for (int i = 0; i < int'(LAT); i++) apply("ones_plus_ones", ones, ones);
        exp_w = ones;
        exp_w[0] = 1'b0;
        chk_out("ones_plus_ones_const", out, exp_w);
        chk_cy("ones_plus_ones_const", carry_out, 1'b1);

        // Asynchronous reset between edges while out is nonzero.
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", out, '0);
        chk_cy("async_reset", carry_out, 1'b0);
        @(posedge clk);
        #1;
        chk_out("reset_over_edge", out, '0);
        chk_cy("reset_over_edge", carry_out, 1'b0);
        #2;
        rst_n = 1'b1;
        model_reset();
        ra = rnd_word();
        rb = rnd_word();
        apply("after_release", ra, rb);
        apply("after_release2", ra, rb);

        // Random stream, with some operand pairs biased toward long carries.
        for (int n = 0; n < 200; n++) begin
            ra = rnd_word();
            case ($urandom_range(0, 3))
                0: rb = ~ra;
                1: rb = ~ra + 1'b1;
                default: rb = rnd_word();
            endcase
            apply("random", ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
